uart_duty_rx: RTL and testbench

Serial command receiver that sits directly upstream of the PWM generator and supplies its 8-bit duty input. It deserialises 8N1 UART bytes from an external host with 16x oversampling. It parses a three-byte frame (sync, duty, checksum) and updates a held duty register only when the frame validates. The duty register drives the PWM generator's duty input directly.

---
 rtl/uart_duty_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_duty_rx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_duty_rx.sv
// 8N1 UART command receiver with 16x oversampling; validates sync/duty/checksum
// frames and holds the accepted duty value for the downstream PWM generator.
module uart_duty_rx #(
  parameter int unsigned BAUD_DIV  = 65,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] duty_o,
  output logic       duty_valid_o,
  output logic       frame_err_o,
  output logic       chk_err_o,
  output logic       busy_o
);

  localparam int unsigned TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_SYNC,
    P_DUTY,
    P_CHK
  } p_state_t;

  rx_state_t      rx_state;
  p_state_t       p_state;
  logic           rx_m;
  logic           rx_s;
  logic           rx_d;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic           start_edge;
  logic [3:0]     samp_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           stop_done;
  logic           stop_ok;
  logic           byte_strobe;
  logic [7:0]     byte_data;
  logic [7:0]     cand;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  // Reset to the idle level so reset release never fakes a start edge.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign start_edge = (rx_state == RX_IDLE) && rx_d && !rx_s;
  assign tick       = (rx_state != RX_IDLE) && (tick_cnt == TICK_LAST);

  // Oversample tick divider; parked at zero while idle so a start edge begins a fresh period.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt <= '0;
    end else if (rx_state == RX_IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Bit receiver: start verify at tick 8, then one sample every 16 ticks.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_state  <= RX_IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      stop_done <= 1'b0;
      stop_ok   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      stop_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (start_edge) begin
            rx_state <= RX_START;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            busy_o   <= 1'b1;
          end
        end
        RX_START: begin
          if (tick) begin
            if (samp_cnt == 4'd7) begin
              samp_cnt <= '0;
              if (!rx_s) begin
                rx_state <= RX_DATA;
              end else begin
                rx_state <= RX_IDLE;
                busy_o   <= 1'b0;
              end
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (samp_cnt == 4'd15) begin
              samp_cnt <= '0;
              shift    <= {rx_s, shift[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_state <= RX_STOP;
              end
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (samp_cnt == 4'd15) begin
              samp_cnt  <= '0;
              stop_done <= 1'b1;
              stop_ok   <= rx_s;
              rx_state  <= RX_IDLE;
              busy_o    <= 1'b0;
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

  // Registered byte strobe / stop-bit error, one clock after the stop sample.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      byte_strobe <= 1'b0;
      frame_err_o <= 1'b0;
      byte_data   <= '0;
    end else begin
      byte_strobe <= stop_done && stop_ok;
      frame_err_o <= stop_done && !stop_ok;
      if (stop_done) begin
        byte_data <= shift;
      end
    end
  end

  // Frame parser: sync, candidate duty, inverted-duty checksum.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      p_state      <= P_SYNC;
      cand         <= '0;
      duty_o       <= '0;
      duty_valid_o <= 1'b0;
      chk_err_o    <= 1'b0;
    end else begin
      duty_valid_o <= 1'b0;
      chk_err_o    <= 1'b0;
      if (frame_err_o) begin
        p_state <= P_SYNC;
        cand    <= '0;
      end else if (byte_strobe) begin
        case (p_state)
          P_SYNC: begin
            if (byte_data == SYNC_BYTE) begin
              p_state <= P_DUTY;
            end
          end
          P_DUTY: begin
            cand    <= byte_data;
            p_state <= P_CHK;
          end
          P_CHK: begin
            if (byte_data == ~cand) begin
              duty_o       <= cand;
              duty_valid_o <= 1'b1;
            end else begin
              chk_err_o <= 1'b1;
            end
            p_state <= P_SYNC;
          end
          default: begin
            p_state <= P_SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_duty_rx.sv
// Bench for uart_duty_rx: drives UART bytes and checks duty updates and error
// pulses against a frame-level reference model.
module tb_uart_duty_rx;

  localparam int unsigned BD       = 3;
  localparam int unsigned BIT_CLKS = 16 * BD;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] duty_o;
  logic       duty_valid_o;
  logic       frame_err_o;
  logic       chk_err_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_duty_rx #(.BAUD_DIV(BD), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .duty_o       (duty_o),
    .duty_valid_o (duty_valid_o),
    .frame_err_o  (frame_err_o),
    .chk_err_o    (chk_err_o),
    .busy_o       (busy_o)
  );

  // Observed pulse log.
  logic [7:0] got_duty_q[$];
  int         got_chk;
  int         got_ferr;
  logic [7:0] duty_prev = 8'h00;

  always @(negedge clk) begin
    if (duty_valid_o === 1'b1) got_duty_q.push_back(duty_o);
    if (chk_err_o === 1'b1) got_chk++;
    if (frame_err_o === 1'b1) got_ferr++;
    if (rst_i === 1'b0 && duty_o !== duty_prev) begin
      checks++;
      if (duty_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL duty_hold: duty_o changed to %h while duty_valid_o=%b (need 1)", duty_o, duty_valid_o);
      end
    end
    duty_prev = duty_o;
  end

  // Reference model: collects bytes of the current frame in a queue.
  logic [7:0] m_frame[$];
  logic [7:0] m_duty;
  logic [7:0] exp_duty_q[$];
  int         exp_chk;
  int         exp_ferr;

  task automatic model_reset();
    m_frame.delete();
    m_duty = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stop);
    if (!stop) begin
      exp_ferr++;
      m_frame.delete();
    end else begin
      if (m_frame.size() != 0 || b == 8'hA5) m_frame.push_back(b);
      if (m_frame.size() == 3) begin
        if ((m_frame[1] ^ m_frame[2]) == 8'hFF) begin
          m_duty = m_frame[1];
          exp_duty_q.push_back(m_frame[1]);
        end else begin
          exp_chk++;
        end
        m_frame.delete();
      end
    end
  endtask

  task automatic clear_logs();
    got_duty_q.delete();
    got_chk  = 0;
    got_ferr = 0;
    exp_duty_q.delete();
    exp_chk  = 0;
    exp_ferr = 0;
  endtask

  // Drives one 8N1 byte starting now (caller is on a negedge); line left at stop level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    model_byte(b, stop);
    rx_i = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_i = stop;
    repeat (BIT_CLKS) @(negedge clk);
    if (!stop) begin
      rx_i = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({duty_o, duty_valid_o, frame_err_o, chk_err_o, busy_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: got duty=%h v=%b fe=%b ce=%b busy=%b, need all 0",
               duty_o, duty_valid_o, frame_err_o, chk_err_o, busy_o);
    end
    rst_i = 1'b0;
    model_reset();
    idle_bits(2);
    send_byte(8'hA5, 1'b1); send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1);
    idle_bits(1);
    checks++;
    if (duty_o !== 8'h77) begin
      errors++; $display("FAIL pre_reset_duty: got %h need 77", duty_o);
    end
    send_byte(8'hA5, 1'b1);
    rx_i = 1'b0;
    repeat (5 * BIT_CLKS) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL busy_mid_byte: got %b need 1", busy_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({duty_o, duty_valid_o, frame_err_o, chk_err_o, busy_o} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got duty=%h v=%b fe=%b ce=%b busy=%b, need all 0",
               duty_o, duty_valid_o, frame_err_o, chk_err_o, busy_o);
    end
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    clear_logs();
    idle_bits(1);
    send_byte(8'hC3, 1'b1); send_byte(8'h3C, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'hC3, 1'b1);
    idle_bits(1);
    checks++;
    if (got_duty_q.size() != 1 || exp_duty_q.size() != 1 || got_duty_q[0] !== 8'h3C) begin
      errors++; $display("FAIL post_reset_frame: got %0d pulses, need exactly one with 3C", got_duty_q.size());
    end
    checks++;
    if (duty_o !== 8'h3C || duty_o !== m_duty) begin
      errors++; $display("FAIL post_reset_duty: got %h need 3C (model %h)", duty_o, m_duty);
    end
  endtask

  task automatic test_valid_timing();
    clear_logs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h80, 1'b1);
    fork
      send_byte(8'h7F, 1'b1);
      begin
        // Start edge is seen on the 3rd posedge; stop sample 152*BD later.
        repeat (152 * BD + 2) @(posedge clk);
        #1 checks++;
        if (busy_o !== 1'b1) begin
          errors++; $display("FAIL busy_before_stop: got %b need 1", busy_o);
        end
        @(posedge clk); #1 checks++;
        if (busy_o !== 1'b0) begin
          errors++; $display("FAIL busy_after_stop: got %b need 0", busy_o);
        end
        @(posedge clk); #1 checks++;
        if (duty_valid_o !== 1'b0) begin
          errors++; $display("FAIL valid_early: got %b need 0 one clk after stop sample", duty_valid_o);
        end
        @(posedge clk); #1 checks++;
        if (duty_valid_o !== 1'b1 || duty_o !== 8'h80) begin
          errors++; $display("FAIL valid_timing: got v=%b duty=%h need v=1 duty=80", duty_valid_o, duty_o);
        end
        @(posedge clk); #1 checks++;
        if (duty_valid_o !== 1'b0 || duty_o !== 8'h80) begin
          errors++; $display("FAIL valid_width: got v=%b duty=%h need v=0 duty=80", duty_valid_o, duty_o);
        end
      end
    join
    idle_bits(2);
    checks++;
    if (got_duty_q.size() != 1 || duty_o !== m_duty || duty_o !== 8'h80) begin
      errors++; $display("FAIL valid_held: got %0d pulses duty=%h need 1 pulse duty=80", got_duty_q.size(), duty_o);
    end
  endtask

  task automatic test_bad_checksum();
    clear_logs();
    send_byte(8'hA5, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h40, 1'b1);
    idle_bits(1);
    checks++;
    if (got_chk != exp_chk || got_chk != 1 || got_duty_q.size() != 0 || duty_o !== 8'h80) begin
      errors++;
      $display("FAIL bad_chk: got chk=%0d pulses=%0d duty=%h need chk=1 pulses=0 duty=80",
               got_chk, got_duty_q.size(), duty_o);
    end
    send_byte(8'hA5, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'hBF, 1'b1);
    idle_bits(1);
    checks++;
    if (duty_o !== 8'h40 || got_duty_q.size() != 1 || got_chk != 1) begin
      errors++; $display("FAIL good_after_bad: got duty=%h pulses=%0d chk=%0d need 40/1/1",
                         duty_o, got_duty_q.size(), got_chk);
    end
  endtask

  task automatic test_resync();
    logic [7:0] seq[6];
    seq = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'hA5, 8'h5A};
    clear_logs();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    idle_bits(1);
    checks++;
    if (duty_o !== 8'hA5 || duty_o !== m_duty || got_duty_q.size() != 1 || got_chk != 0) begin
      errors++; $display("FAIL resync: got duty=%h pulses=%0d chk=%0d need A5/1/0",
                         duty_o, got_duty_q.size(), got_chk);
    end
  endtask

  task automatic test_glitch();
    clear_logs();
    rx_i = 1'b0;
    repeat (4 * BD) @(negedge clk);
    rx_i = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL glitch_busy_rise: got %b need 1", busy_o);
    end
    repeat (8 * BD) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL glitch_busy_fall: got %b need 0", busy_o);
    end
    idle_bits(1);
    checks++;
    if (got_duty_q.size() != 0 || got_chk != 0 || got_ferr != 0 || duty_o !== 8'hA5) begin
      errors++; $display("FAIL glitch_quiet: got pulses=%0d chk=%0d ferr=%0d duty=%h need 0/0/0/A5",
                         got_duty_q.size(), got_chk, got_ferr, duty_o);
    end
  endtask

  task automatic test_frame_err();
    clear_logs();
    send_byte(8'hA5, 1'b1);
    send_byte(8'($urandom), 1'b0);
    send_byte(8'h3C, 1'b1); send_byte(8'hC3, 1'b1);
    idle_bits(1);
    checks++;
    if (got_ferr != exp_ferr || got_ferr != 1) begin
      errors++; $display("FAIL frame_err_count: got %0d need 1", got_ferr);
    end
    checks++;
    if (got_duty_q.size() != 0 || duty_o !== m_duty || duty_o !== 8'hA5) begin
      errors++; $display("FAIL frame_err_resync: got pulses=%0d duty=%h need 0 pulses duty=A5",
                         got_duty_q.size(), duty_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[9];
    logic [7:0] want[3];
    seq  = '{8'hA5, 8'h01, 8'hFE, 8'hA5, 8'hFF, 8'h00, 8'hA5, 8'h00, 8'hFF};
    want = '{8'h01, 8'hFF, 8'h00};
    clear_logs();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    idle_bits(1);
    checks++;
    if (got_duty_q.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d pulses need 3", got_duty_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_duty_q[i] !== want[i] || got_duty_q[i] !== exp_duty_q[i]) begin
          errors++; $display("FAIL b2b_value%0d: got %h need %h", i, got_duty_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] c;
    clear_logs();
    for (int f = 0; f < 5; f++) begin
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom), 1'b1);
      d = 8'($urandom);
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~d;
      send_byte(8'hA5, 1'b1); send_byte(d, 1'b1); send_byte(c, 1'b1);
      if ($urandom_range(0, 1) == 0) idle_bits(int'($urandom_range(1, 2)));
    end
    idle_bits(1);
    checks++;
    if (got_duty_q.size() != exp_duty_q.size() || got_chk != exp_chk || got_ferr != exp_ferr) begin
      errors++; $display("FAIL rand_counts: got pulses=%0d chk=%0d ferr=%0d need %0d/%0d/%0d",
                         got_duty_q.size(), got_chk, got_ferr, exp_duty_q.size(), exp_chk, exp_ferr);
    end else begin
      foreach (exp_duty_q[i]) begin
        checks++;
        if (got_duty_q[i] !== exp_duty_q[i]) begin
          errors++; $display("FAIL rand_value%0d: got %h need %h", i, got_duty_q[i], exp_duty_q[i]);
        end
      end
    end
    checks++;
    if (duty_o !== m_duty) begin
      errors++; $display("FAIL rand_final_duty: got %h need %h", duty_o, m_duty);
    end
  endtask

  initial begin
    rx_i  = 1'b1;
    rst_i = 1'b1;
    model_reset();
    clear_logs();
    repeat (3) @(negedge clk);
    test_reset();
    test_valid_timing();
    test_bad_checksum();
    test_resync();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
